// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared types and constants for the 5:1 mux scan serializer
package mux_scan_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, PAR} scan_state_t;

  localparam int N_IN  = 5;
  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] SEL_LAST = 3'd4;

endpackage

// File: rtl/mux5_scan_serializer.sv
// rtl/mux5_scan_serializer.sv - serializes a 5-bit word through the external 5:1 mux
// Optional trailing even-parity beat when SCAN_PARITY_EN is defined.
module mux5_scan_serializer
  import mux_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [N_IN-1:0]  load_data,
  output logic [N_IN-1:0]  mux_i,
  output logic [SEL_W-1:0] mux_sel,
  input  logic             mux_y,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_data,
  output logic             ser_last
);

  scan_state_t      state_q, state_d;
  logic [N_IN-1:0]  mux_i_d;
  logic [SEL_W-1:0] mux_sel_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mux_i   <= '0;
      mux_sel <= '0;
    end else begin
      state_q <= state_d;
      mux_i   <= mux_i_d;
      mux_sel <= mux_sel_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mux_i_d    = mux_i;
    mux_sel_d  = mux_sel;
    load_ready = 1'b0;
    ser_valid  = 1'b0;
    ser_data   = 1'b0;
    ser_last   = 1'b0;
    case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          mux_i_d   = load_data;
          mux_sel_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_data  = mux_y;
`ifdef SCAN_PARITY_EN
        ser_last  = 1'b0;
`else
        ser_last  = (mux_sel == SEL_LAST);
`endif
        // mux_sel saturates at SEL_LAST so the mux never sees 5..7
        if (ser_ready) begin
          if (mux_sel != SEL_LAST) begin
            mux_sel_d = mux_sel + 3'd1;
          end else begin
`ifdef SCAN_PARITY_EN
            state_d   = PAR;
`else
            state_d   = IDLE;
            mux_sel_d = '0;
`endif
          end
        end
      end
`ifdef SCAN_PARITY_EN
      PAR: begin
        ser_valid = 1'b1;
        ser_data  = ^mux_i;
        ser_last  = 1'b1;
        if (ser_ready) begin
          state_d   = IDLE;
          mux_sel_d = '0;
        end
      end
`endif
      default: begin
        state_d   = IDLE;
        mux_sel_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux5_scan_serializer.sv
// tb/tb_mux5_scan_serializer.sv - self-checking bench with a behavioural 5:1 mux beside the DUT
module tb_mux5_scan_serializer;
  import mux_scan_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             load_valid;
  logic             load_ready;
  logic [N_IN-1:0]  load_data;
  logic [N_IN-1:0]  mux_i;
  logic [SEL_W-1:0] mux_sel;
  logic             mux_y;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_data;
  logic             ser_last;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Stand-in for mux_5_1_st: out-of-range selects return 0
  always_comb begin
    mux_y = 1'b0;
    case (mux_sel)
      3'd0: mux_y = mux_i[0];
      3'd1: mux_y = mux_i[1];
      3'd2: mux_y = mux_i[2];
      3'd3: mux_y = mux_i[3];
      3'd4: mux_y = mux_i[4];
      default: mux_y = 1'b0;
    endcase
  end

  mux5_scan_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .mux_i      (mux_i),
    .mux_sel    (mux_sel),
    .mux_y      (mux_y),
    .ser_valid  (ser_valid),
    .ser_ready  (ser_ready),
    .ser_data   (ser_data),
    .ser_last   (ser_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef SCAN_PARITY_EN
  localparam int BEATS = N_IN + 1;
`else
  localparam int BEATS = N_IN;
`endif

  // mode 0: ready always high; 1: ready pattern 1,0,0 repeating; 2: random ready
  task automatic run_frame(input logic [N_IN-1:0] d, input int mode);
    int k;
    int cyc;
    int wait_cnt;
    logic exp_bit;
    logic stalled;
    logic [SEL_W-1:0] prev_sel;
    logic prev_last;
    wait_cnt = 0;
    while (!load_ready && wait_cnt < 20) begin
      tick();
      wait_cnt++;
    end
    check("load_ready_wait", {31'd0, load_ready}, 32'd1);
    load_valid = 1'b1;
    load_data  = d;
    ser_ready  = 1'b0;
    tick();
    load_valid = 1'b0;
    load_data  = ~d;
    check("first_valid", {31'd0, ser_valid}, 32'd1);
    k = 0;
    cyc = 0;
    stalled = 1'b0;
    prev_sel = '0;
    prev_last = 1'b0;
    while (k < BEATS && cyc < 100) begin
      case (mode)
        0: ser_ready = 1'b1;
        1: ser_ready = (cyc % 3 == 0);
        default: ser_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (mux_sel > SEL_LAST) check("sel_range", {29'd0, mux_sel}, {29'd0, SEL_LAST});
      if (stalled) begin
        check("stall_valid", {31'd0, ser_valid}, 32'd1);
        check("stall_sel", {29'd0, mux_sel}, {29'd0, prev_sel});
        check("stall_last", {31'd0, ser_last}, {31'd0, prev_last});
      end
      if (ser_valid && ser_ready) begin
        exp_bit = (k < N_IN) ? d[k] : ^d;
        check($sformatf("beat%0d_data", k), {31'd0, ser_data}, {31'd0, exp_bit});
        check($sformatf("beat%0d_last", k), {31'd0, ser_last}, {31'd0, (k == BEATS - 1)});
        k++;
        stalled = 1'b0;
      end else begin
        stalled = ser_valid;
      end
      prev_sel = mux_sel;
      prev_last = ser_last;
      tick();
      cyc++;
    end
    check("frame_beats", k, BEATS);
    ser_ready = 1'b0;
    check("post_ready", {31'd0, load_ready}, 32'd1);
    check("post_valid", {31'd0, ser_valid}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    ser_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_load_ready", {31'd0, load_ready}, 32'd1);
    check("rst_ser_valid", {31'd0, ser_valid}, 32'd0);
    check("rst_mux_sel", {29'd0, mux_sel}, 32'd0);
    check("rst_mux_i", {27'd0, mux_i}, 32'd0);

    run_frame(5'b10110, 0);
    run_frame(5'b00001, 1);
    run_frame(5'b11110, 0);

    // reset while beat 2 of 5'b11111 is on the wire
    load_valid = 1'b1;
    load_data  = 5'b11111;
    tick();
    load_valid = 1'b0;
    ser_ready  = 1'b1;
    tick();
    tick();
    check("mid_sel", {29'd0, mux_sel}, 32'd2);
    ser_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", {31'd0, ser_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, load_ready}, 32'd1);
    check("mid_rst_sel", {29'd0, mux_sel}, 32'd0);
    ser_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_rst_quiet", {31'd0, ser_valid}, 32'd0);
    end
    ser_ready = 1'b0;
    run_frame(5'b01010, 0);

    for (int f = 0; f < 50; f++) begin
      run_frame(5'($urandom_range(0, 31)), 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
